// File: rtl/banco_registradores_if.sv
// Operand-fetch bus for banco_registradores.
//   Write port : escrita_en, escrita_end, escrita_dado
//   Read request (upstream handshake) : leitura_val, leitura_pronta, end_a, end_b
//   Operand pair (downstream handshake) : saida_val, saida_pronta, entrada1, entrada2
// master = producer of writes/requests and consumer of operand pairs; slave = the register file.
interface banco_registradores_if #(
  parameter int unsigned LARGURA  = 32,
  parameter int unsigned END_BITS = 4
);
  logic                escrita_en;
  logic [END_BITS-1:0] escrita_end;
  logic [LARGURA-1:0]  escrita_dado;
  logic                leitura_val;
  logic                leitura_pronta;
  logic [END_BITS-1:0] end_a;
  logic [END_BITS-1:0] end_b;
  logic                saida_val;
  logic                saida_pronta;
  logic [LARGURA-1:0]  entrada1;
  logic [LARGURA-1:0]  entrada2;

  modport master (
    output escrita_en, escrita_end, escrita_dado,
    output leitura_val, end_a, end_b,
    input  leitura_pronta,
    input  saida_val, entrada1, entrada2,
    output saida_pronta
  );

  modport slave (
    input  escrita_en, escrita_end, escrita_dado,
    input  leitura_val, end_a, end_b,
    output leitura_pronta,
    output saida_val, entrada1, entrada2,
    input  saida_pronta
  );
endinterface

// File: rtl/banco_registradores.sv
// banco_registradores: register file plus operand-fetch pipeline register feeding the Somador
// adder. Two source registers are read, captured into entrada1/entrada2 and handed downstream
// with a valid/ready handshake; one write port takes writeback results.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears all registers and the operand stage
//   bus    - banco_registradores_if.slave (write port, read request, operand pair)
// Configuration:
//   BANCO_BYPASS_EN - when defined, a same-cycle write to a source register is forwarded into
//                     the captured operand; otherwise the old value is captured.
module banco_registradores #(
  parameter int unsigned LARGURA  = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned END_BITS = 4
) (
  input logic                  clock,
  input logic                  reset,
  banco_registradores_if.slave bus
);

  logic [LARGURA-1:0] regs_q [NUM_REGS];
  logic               saida_val_q;
  logic [LARGURA-1:0] entrada1_q;
  logic [LARGURA-1:0] entrada2_q;

  logic               escrita_valida;
  logic               aceita;
  logic [LARGURA-1:0] leitura_a;
  logic [LARGURA-1:0] leitura_b;

  // Register 0 and out-of-range addresses are never written.
  assign escrita_valida = bus.escrita_en && (bus.escrita_end != '0) &&
                          (32'(bus.escrita_end) < NUM_REGS);

  assign bus.leitura_pronta = !saida_val_q || bus.saida_pronta;
  assign aceita             = bus.leitura_val && bus.leitura_pronta;

  // Register 0 and out-of-range addresses read as zero.
  always_comb begin
    leitura_a = '0;
    leitura_b = '0;
    if ((bus.end_a != '0) && (32'(bus.end_a) < NUM_REGS)) leitura_a = regs_q[bus.end_a];
    if ((bus.end_b != '0) && (32'(bus.end_b) < NUM_REGS)) leitura_b = regs_q[bus.end_b];
`ifdef BANCO_BYPASS_EN
    // Write-through forwarding; escrita_valida already excludes r0 and out-of-range targets.
    if (escrita_valida && (bus.escrita_end == bus.end_a)) leitura_a = bus.escrita_dado;
    if (escrita_valida && (bus.escrita_end == bus.end_b)) leitura_b = bus.escrita_dado;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (escrita_valida) begin
      regs_q[bus.escrita_end] <= bus.escrita_dado;
    end
  end

  // Operands are snapshots: once captured they only change on the next accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_val_q <= 1'b0;
      entrada1_q  <= '0;
      entrada2_q  <= '0;
    end else if (aceita) begin
      saida_val_q <= 1'b1;
      entrada1_q  <= leitura_a;
      entrada2_q  <= leitura_b;
    end else if (bus.saida_pronta) begin
      saida_val_q <= 1'b0;
    end
  end

  assign bus.saida_val = saida_val_q;
  assign bus.entrada1  = entrada1_q;
  assign bus.entrada2  = entrada2_q;

endmodule

// File: tb/tb_banco_registradores.sv
module tb_banco_registradores;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  banco_registradores_if #(.LARGURA(32), .END_BITS(4)) bus ();

  banco_registradores #(
    .LARGURA (32),
    .NUM_REGS(16),
    .END_BITS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pair(input string tag, input logic v, input logic [31:0] a,
                      input logic [31:0] b);
    check({tag, "_val"}, 32'(bus.saida_val), 32'(v));
    check({tag, "_e1"}, bus.entrada1, a);
    check({tag, "_e2"}, bus.entrada2, b);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] dado);
    bus.escrita_en   = 1'b1;
    bus.escrita_end  = addr;
    bus.escrita_dado = dado;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    bus.leitura_val = 1'b1;
    bus.end_a       = a;
    bus.end_b       = b;
  endtask

  initial begin
    logic [31:0] exp_fwd;
    n_checks = 0;
    n_fails  = 0;
    reset            = 1'b1;
    bus.escrita_en   = 1'b0;
    bus.escrita_end  = '0;
    bus.escrita_dado = '0;
    bus.leitura_val  = 1'b0;
    bus.end_a        = '0;
    bus.end_b        = '0;
    bus.saida_pronta = 1'b1;

    // 1. reset, then read r3,r5
    step();
    step();
    pair("reset", 1'b0, 32'h0, 32'h0);
    check("reset_pronta", 32'(bus.leitura_pronta), 32'd1);
    reset = 1'b0;
    rd(4'd3, 4'd5);
    step();
    pair("rd_r3_r5", 1'b1, 32'h0, 32'h0);
    bus.leitura_val = 1'b0;

    // 2. write r1=1, r2=3, read 1,2
    wr(4'd1, 32'd1);
    step();
    check("drain_val", 32'(bus.saida_val), 32'd0);
    wr(4'd2, 32'd3);
    step();
    bus.escrita_en = 1'b0;
    rd(4'd1, 4'd2);
    step();
    pair("rd_r1_r2", 1'b1, 32'd1, 32'd3);
    bus.leitura_val = 1'b0;

    // 3. r0 ignores writes
    wr(4'd0, 32'hFFFF_FFFF);
    step();
    bus.escrita_en = 1'b0;
    rd(4'd0, 4'd0);
    step();
    pair("rd_r0", 1'b1, 32'h0, 32'h0);
    bus.leitura_val = 1'b0;

    // 4. same-cycle write/read of r4 (old value 2)
    wr(4'd4, 32'd2);
    step();
    wr(4'd4, 32'd7);
    rd(4'd4, 4'd4);
    step();
`ifdef BANCO_BYPASS_EN
    exp_fwd = 32'd7;
`else
    exp_fwd = 32'd2;
`endif
    pair("rw_r4", 1'b1, exp_fwd, exp_fwd);
    bus.escrita_en = 1'b0;
    step();
    pair("rd_r4_after", 1'b1, 32'd7, 32'd7);

    // 5. stall with snapshot semantics
    rd(4'd1, 4'd2);
    step();
    pair("cap_1_3", 1'b1, 32'd1, 32'd3);
    bus.saida_pronta = 1'b0;
    #1;
    check("stall_pronta", 32'(bus.leitura_pronta), 32'd0);
    wr(4'd1, 32'd9);
    step();
    pair("stall_hold1", 1'b1, 32'd1, 32'd3);
    check("stall_pronta2", 32'(bus.leitura_pronta), 32'd0);
    bus.escrita_en = 1'b0;
    step();
    pair("stall_hold2", 1'b1, 32'd1, 32'd3);
    bus.saida_pronta = 1'b1;
    #1;
    check("release_pronta", 32'(bus.leitura_pronta), 32'd1);
    step();
    pair("release_cap", 1'b1, 32'd9, 32'd3);

    // Back-to-back pairs, then drain keeps operands
    rd(4'd4, 4'd1);
    step();
    pair("b2b_0", 1'b1, 32'd7, 32'd9);
    rd(4'd2, 4'd4);
    step();
    pair("b2b_1", 1'b1, 32'd3, 32'd7);
    bus.leitura_val = 1'b0;
    step();
    pair("drain_keep", 1'b0, 32'd3, 32'd7);

    // 6. reset while a pair is stalled; writes during reset are dropped
    rd(4'd1, 4'd4);
    step();
    pair("pre_reset", 1'b1, 32'd9, 32'd7);
    bus.leitura_val  = 1'b0;
    bus.saida_pronta = 1'b0;
    step();
    check("pre_reset_hold", 32'(bus.saida_val), 32'd1);
    reset = 1'b1;
    wr(4'd5, 32'd55);
    rd(4'd2, 4'd2);
    step();
    pair("mid_reset", 1'b0, 32'h0, 32'h0);
    reset            = 1'b0;
    bus.escrita_en   = 1'b0;
    bus.saida_pronta = 1'b1;
    rd(4'd1, 4'd4);
    step();
    pair("post_reset_r1_r4", 1'b1, 32'h0, 32'h0);
    rd(4'd5, 4'd2);
    step();
    pair("post_reset_r5_r2", 1'b1, 32'h0, 32'h0);
    bus.leitura_val = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
